fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the multi-cycle RV32I core. Holds the PC, issues one request per instruction to instruction memory and captures the returned word. It presents the word and its decoded fields (opcode, func3, func7, register indices) to the control unit. The PC advances only on the control unit's one-cycle `PC_stall` low pulse, to PC+4 or to the target selected by `PC_MUX_sel`.

## Interface
- `WIDTH`, 32, data and address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PC_stall` in 1: 1 = hold. Low for one cycle = advance request.
- `PC_MUX_sel` in 1: advance select. 0 = PC+4, 1 = `branch_target`.
- `branch_target` in WIDTH: next PC when `PC_MUX_sel`=1.
- `im_req` out 1: instruction-memory request.
- `im_addr` out WIDTH: request address; equals `pc`.
- `im_gnt` in 1: memory accepted the request.
- `im_rvalid` in 1: `im_rdata` valid.
- `im_rdata` in 32: returned instruction word.
- `pc` out WIDTH: address of the held or in-flight instruction.
- `pc_plus4` out WIDTH: `pc`+4, combinational.
- `instr` out 32: held instruction register.
- `instr_valid` out 1: `instr` belongs to the current `pc`.
- `opcode` out 7, `func3` out 3, `func7` out 7: `instr[6:0]`, `instr[14:12]`, `instr[31:25]`.
- `rd` out 5, `rs1` out 5, `rs2` out 5: `instr[11:7]`, `instr[19:15]`, `instr[24:20]`.
- `misalign_err` out 1: sticky misaligned-target flag. Exists only under `FETCH_MISALIGN_TRAP_EN`.

## Operation
- States: REQ, WAIT, HOLD, HALT. HALT exists only under `FETCH_MISALIGN_TRAP_EN`.
- Reset values:
  - state=REQ, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `misalign_err`=0.
- REQ:
  - `im_req`=1 (combinational from state).
  - `im_gnt`=1 and `im_rvalid`=0 -> WAIT.
  - `im_gnt`=1 and `im_rvalid`=1 (zero-wait memory) -> latch `instr`, set `instr_valid`, go to HOLD.
  - `im_rvalid` without `im_gnt` is ignored; this covers a stale response after reset.
- WAIT:
  - `im_req`=0.
  - On `im_rvalid`: `instr`<=`im_rdata`, `instr_valid`<=1, go to HOLD.
- HOLD:
  - `instr` and `pc` are stable.
  - On `PC_stall`=0: `pc`<=(`PC_MUX_sel` ? `branch_target` : `pc`+4), `instr_valid`<=0, go to REQ.
- `PC_stall`=0 in REQ or WAIT is ignored; no queued advance.
- `pc`+4 wraps modulo 2^WIDTH.
- `rst` asserted in any state returns to reset values next edge and drops any in-flight fetch.
- Decode fields are pure slices of `instr`; they show the NOP encoding after reset.

## Timing
- Advance sampled at edge N -> new `pc` visible after N, `im_req` high in cycle N+1.
- Memory with grant in cycle N+1 and `im_rvalid` in N+2:
  - `instr_valid`=1 after edge N+2.
  - Advance to valid instruction = 3 cycles.
- Zero-wait memory (`im_gnt` and `im_rvalid` both in N+1): 2 cycles.
- `im_gnt` held low: stays in REQ indefinitely, `im_addr` stable.
- No combinational path from `im_rdata` to any output except through `instr`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - Advance with `PC_MUX_sel`=1 and `branch_target[1:0]`≠0 sets `misalign_err`=1, leaves `pc` unchanged and enters HALT.
  - HALT: `im_req`=0, `instr_valid`=0; exits only on `rst`.
- Not defined:
  - The `misalign_err` port is absent.
  - `pc` loads `{branch_target[WIDTH-1:2],2'b00}`; no HALT state.

## Test plan
- Reset, memory grants immediately with `im_rvalid` next cycle, `im_rdata`=32'h0050_0093 -> `im_addr`=0; `instr_valid`=1 two cycles after reset release; `opcode`=7'h13, `rd`=1, `func3`=0.
- In HOLD, pulse `PC_stall`=0 with `PC_MUX_sel`=0 -> `pc`=4, `instr_valid`=0, `im_req` high the next cycle.
- In HOLD at `pc`=8, `PC_MUX_sel`=1, `branch_target`=32'h100 -> `im_addr`=32'h100. A `PC_stall` pulse during WAIT has no effect.
- `pc`=32'hFFFF_FFFC, advance with `PC_MUX_sel`=0 -> `pc`=0.
- Assert `rst` in WAIT, then deliver `im_rvalid` without `im_gnt` -> `instr` stays 32'h13, `pc`=`RESET_PC`, a fresh request is issued.
- `branch_target`=32'h102:
  - Macro on -> `misalign_err`=1, `im_req`=0 until reset.
  - Macro off -> `pc`=32'h100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I multi-cycle fetch stage holding the PC and the current instruction.
// Inputs:  clk, rst, PC_stall, PC_MUX_sel, branch_target, im_gnt, im_rvalid, im_rdata.
// Outputs: im_req, im_addr, pc, pc_plus4, instr, instr_valid, opcode, func3, func7, rd, rs1, rs2,
//          and misalign_err with HALT state when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_stall,
  input  logic             PC_MUX_sel,
  input  logic [WIDTH-1:0] branch_target,
  output logic             im_req,
  output logic [WIDTH-1:0] im_addr,
  input  logic             im_gnt,
  input  logic             im_rvalid,
  input  logic [31:0]      im_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [31:0]      instr,
  output logic             instr_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic             misalign_err,
`endif
  output logic [6:0]       opcode,
  output logic [2:0]       func3,
  output logic [6:0]       func7,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2
);
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;
  logic err_q, err_d;
`else
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic valid_q, valid_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_d = err_q;
`endif
    case (state_q)
      REQ: if (im_gnt) begin
        state_d = im_rvalid ? HOLD : WAIT;
        instr_d = im_rvalid ? im_rdata : instr_q;
        valid_d = im_rvalid;
      end
      WAIT: if (im_rvalid) begin
        state_d = HOLD;
        instr_d = im_rdata;
        valid_d = 1'b1;
      end
      HOLD: if (!PC_stall) begin
        valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (PC_MUX_sel && |branch_target[1:0]) begin
          err_d = 1'b1;
          state_d = HALT;
        end else begin
          state_d = REQ;
          pc_d = PC_MUX_sel ? branch_target : pc_plus4;
        end
`else
        state_d = REQ;
        pc_d = PC_MUX_sel ? (branch_target & ~WIDTH'(3)) : pc_plus4;
`endif
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      instr_q <= 32'h0000_0013;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q <= err_d;
`endif
    end
  end
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_err = err_q;
`endif
  assign im_req = state_q == REQ;
  assign im_addr = pc_q;
  assign pc = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign instr = instr_q;
  assign instr_valid = valid_q;
  assign opcode = instr_q[6:0];
  assign func3 = instr_q[14:12];
  assign func7 = instr_q[31:25];
  assign rd = instr_q[11:7];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
endmodule
